// File: rtl/keycode_event.sv
// Keycode debouncer and key event generator.
// Registers the raw keycode, requires it to hold steady before it is accepted,
// then emits press/release/auto-repeat strobes and game-control decodes.
//
// state  | meaning
// IDLE   | no key accepted (cur_key == 0)
// HELD   | nonzero key accepted, waiting for the first repeat
// REPEAT | nonzero key accepted, emitting repeats at the repeat rate
module keycode_event #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_RATE   = 2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  output logic [7:0] cur_key,
  output logic       key_held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       move_left,
  output logic       move_right,
  output logic       crouch,
  output logic       jump_pulse
);

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RATE_LAST   = 24'(REPEAT_RATE - 1);

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  kc_q;
  logic [7:0]  cand;
  logic [7:0]  stable_cnt;
  logic [23:0] hold_cnt, hold_next;
  logic        accept;
  logic        jump_key;
  logic        press_next, release_next, repeat_next, jump_next;

  // Input register plus stability tracking: a new value restarts the count,
  // an unchanged value counts up and parks at the acceptance threshold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kc_q       <= 8'h00;
      cand       <= 8'h00;
      stable_cnt <= 8'h00;
    end else begin
      kc_q <= keycode;
      if (kc_q != cand) begin
        cand       <= kc_q;
        stable_cnt <= 8'h00;
      end else if (stable_cnt != STABLE_LAST) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  assign accept   = (kc_q == cand) && (stable_cnt == STABLE_LAST) && (cand != cur_key);
  assign jump_key = (cand == KEY_W) || (cand == KEY_SPACE);

  // Next-state and pulse decisions; a key acceptance always wins over a repeat.
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    jump_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = HELD;
          hold_next  = 24'd0;
          press_next = 1'b1;
          jump_next  = jump_key;
        end
      end
      HELD, REPEAT: begin
        if (accept) begin
          release_next = 1'b1;
          hold_next    = 24'd0;
          if (cand == 8'h00) begin
            state_next = IDLE;
          end else begin
            state_next = HELD;
            press_next = 1'b1;
            jump_next  = jump_key;
          end
        end else if (hold_cnt == ((state == HELD) ? DELAY_LAST : RATE_LAST)) begin
          repeat_next = 1'b1;
          hold_next   = 24'd0;
          state_next  = REPEAT;
        end else begin
          hold_next = hold_cnt + 24'd1;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = 24'd0;
      end
    endcase
  end

  // State, hold timer, accepted key and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold_cnt      <= 24'd0;
      cur_key       <= 8'h00;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      jump_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      if (accept) cur_key <= cand;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      repeat_pulse  <= repeat_next;
      jump_pulse    <= jump_next;
    end
  end

  assign key_held   = (cur_key != 8'h00);
  assign move_left  = (cur_key == KEY_A);
  assign move_right = (cur_key == KEY_D);
  assign crouch     = (cur_key == KEY_S);

endmodule

// File: tb/tb_keycode_event.sv
// Testbench for keycode_event: directed scenarios plus randomized key traffic,
// every cycle compared against a sample-history reference model.
module tb_keycode_event;

  localparam int S = 4;
  localparam int D = 20;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keycode;
  logic [7:0] cur_key;
  logic       key_held, press_pulse, release_pulse, repeat_pulse;
  logic       move_left, move_right, crouch, jump_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int cnt_press = 0, cnt_rel = 0, cnt_rep = 0, cnt_jump = 0;

  // reference model: accepted key, last sample, run length, cycles since press
  logic [7:0] m_cur, m_last;
  int         m_run, m_age;
  logic       m_press, m_rel, m_rep, m_jump;

  keycode_event #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .keycode      (keycode),
    .cur_key      (cur_key),
    .key_held     (key_held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .move_left    (move_left),
    .move_right   (move_right),
    .crouch       (crouch),
    .jump_pulse   (jump_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {16'h0, cur_key, key_held, press_pulse, release_pulse, repeat_pulse,
            move_left, move_right, crouch, jump_pulse};
  endfunction

  function automatic logic [31:0] model_outs();
    return {16'h0, m_cur, (m_cur != 8'h00), m_press, m_rel, m_rep,
            (m_cur == 8'h04), (m_cur == 8'h07), (m_cur == 8'h16), m_jump};
  endfunction

  // A key is accepted once S+1 consecutive samples agree and differ from the
  // accepted key; repeats fire D cycles after the press and every R after that.
  task automatic model_edge(input logic rst_n, input logic [7:0] kc);
    m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0; m_jump = 1'b0;
    if (!rst_n) begin
      m_cur = 8'h00; m_last = 8'h00; m_run = 0; m_age = 0;
      return;
    end
    if (m_run >= S + 1 && m_last != m_cur) begin
      if (m_cur != 8'h00) m_rel = 1'b1;
      if (m_last != 8'h00) begin
        m_press = 1'b1;
        m_jump  = (m_last == 8'h1A) || (m_last == 8'h2C);
      end
      m_cur = m_last;
      m_age = 0;
    end else if (m_cur != 8'h00) begin
      m_age++;
      if (m_age >= D && (m_age - D) % R == 0) m_rep = 1'b1;
    end
    if (m_run > 0 && kc == m_last) m_run++;
    else begin
      m_last = kc;
      m_run  = 1;
    end
  endtask

  task automatic tick();
    model_edge(reset_n, keycode);
    @(posedge clk);
    #1;
    chk("cycle", dut_outs(), model_outs());
    cnt_press += int'(press_pulse);
    cnt_rel   += int'(release_pulse);
    cnt_rep   += int'(repeat_pulse);
    cnt_jump  += int'(jump_pulse);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n = cycles from the first edge sampling the key to the press strobe
  task automatic wait_press(output int n);
    n = 60;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (press_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, snap_p, snap_j, snap_r;
    logic [7:0] keys [7];
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h16;
    keys[4] = 8'h1A; keys[5] = 8'h2C; keys[6] = 8'h55;

    reset_n = 1'b0;
    keycode = 8'h00;
    tick();
    tick();
    chk("reset_outs", dut_outs(), 32'h0);
    reset_n = 1'b1;
    ticks(3);

    // press A: move_left, press 5 cycles after change, no jump
    keycode = 8'h04;
    wait_press(n);
    chk("left_latency", n, 5);
    chk("left_levels", {move_left, key_held, jump_pulse}, 3'b110);
    keycode = 8'h00;
    ticks(8);

    // short W glitch is ignored, long space press jumps once
    snap_p = cnt_press; snap_j = cnt_jump;
    keycode = 8'h1A;
    ticks(3);
    keycode = 8'h00;
    ticks(8);
    chk("glitch_press", cnt_press - snap_p, 0);
    keycode = 8'h2C;
    ticks(10);
    chk("space_press", cnt_press - snap_p, 1);
    chk("space_jump", cnt_jump - snap_j, 1);
    keycode = 8'h00;
    ticks(8);

    // D held: five repeats within 40 cycles of the press
    keycode = 8'h07;
    wait_press(n);
    snap_r = cnt_rep;
    ticks(40);
    chk("repeat_count", cnt_rep - snap_r, 5);

    // A then D: release and press together, left falls as right rises
    keycode = 8'h04;
    wait_press(n);
    keycode = 8'h07;
    wait_press(n);
    chk("swap", {release_pulse, press_pulse, move_left, move_right}, 4'b1101);

    // S into repeat, then reset aborts silently and S re-presses
    keycode = 8'h16;
    wait_press(n);
    ticks(25);
    reset_n = 1'b0;
    tick();
    chk("rst_outs", dut_outs(), 32'h0);
    reset_n = 1'b1;
    snap_r = cnt_rel;
    wait_press(n);
    chk("rst_latency", n, 5);
    chk("rst_no_release", cnt_rel - snap_r, 0);

    // release lands on the first-repeat edge: release only
    ticks(14);
    keycode = 8'h00;
    ticks(5);
    tick();
    chk("release_vs_repeat", {release_pulse, repeat_pulse, key_held}, 3'b100);
    ticks(4);

    // randomized key traffic with occasional resets
    for (int it = 0; it < 80; it++) begin
      keycode = keys[$urandom_range(0, 6)];
      if ($urandom_range(0, 14) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      ticks($urandom_range(1, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
